alu_arbiter: RTL and testbench

- Shares one ALUModule instance between NUM_REQ independent requesters.
- Round-robin arbitration, valid/ready request handshake, and operand registering.
- Drives the ALU select and operand inputs; returns a registered result, a zero flag and the requester ID on one response channel.
- Sits between the issue logic of the requesters (execute stages, address-gen, test port) and the shared ALU.

---
 rtl/alu_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one ALU between NUM_REQ
// requesters. A request is accepted in IDLE, its operands are held for one
// EXEC cycle while the ALU evaluates, and the result is held in RESP until
// the consumer takes it.
// Optional build macro: ALU_ARB_STALL_CNT_EN adds a 16-bit saturating
// stall_count output.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int BUS_W  = 32,
  localparam int OP_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][BUS_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][BUS_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0][OP_W-1:0]   req_op,
  output logic [BUS_W-1:0]               alu_a,
  output logic [BUS_W-1:0]               alu_b,
  output logic [OP_W-1:0]                alu_sel,
  input  logic [BUS_W-1:0]               alu_s,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [BUS_W-1:0]               rsp_data,
  output logic                           rsp_zero,
  output logic                           rsp_err
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_count
`endif
);

  // ALU operation encodings (alu_oper_type)
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // True when op is one of the encodings the ALU actually implements.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_SLTU, ALU_NOR: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q;
  logic [BUS_W-1:0]      op_a_q, op_b_q;
  logic [OP_W-1:0]       op_sel_q;
  logic [ID_W-1:0]       op_id_q;
  logic [BUS_W-1:0]      rsp_data_q;
  logic                  rsp_zero_q;
  logic                  rsp_err_q;
  logic [ID_W-1:0]       rsp_id_q;

  logic                  grant_found_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic [ID_W:0]         cand_v;

  // Round-robin search: first valid index starting just after last_grant.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_v        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_v = {1'b0, last_grant_q} + (ID_W+1)'(i);
      if (cand_v >= (ID_W+1)'(NUM_REQ)) begin
        cand_v = cand_v - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_v = cand_v;
      end
      if (!grant_found_s && req_valid[cand_v[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_v[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE when consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: one-hot grant only in IDLE, valid only in RESP.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready[grant_idx_s] = 1'b1;
        end else begin
          req_ready = '0;
        end
      end
      ST_EXEC: rsp_valid = 1'b0;
      ST_RESP: rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Datapath: latch the granted operands, then capture the ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= ALU_ADD;
      op_id_q      <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found_s) begin
            op_a_q       <= req_a[grant_idx_s];
            op_b_q       <= req_b[grant_idx_s];
            op_sel_q     <= req_op[grant_idx_s];
            op_id_q      <= grant_idx_s;
            last_grant_q <= grant_idx_s;
          end
        end
        ST_EXEC: begin
          rsp_id_q <= op_id_q;
          if (is_legal_op(op_sel_q)) begin
            rsp_data_q <= alu_s;
            rsp_zero_q <= (alu_s == {BUS_W{1'b0}});
            rsp_err_q  <= 1'b0;
          end else begin
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b1;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          rsp_data_q <= rsp_data_q;
        end
        default: begin
          rsp_data_q <= rsp_data_q;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where a response waits on the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else if (rsp_valid && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  // ALU inputs come straight from the latched operands, so they only move on a grant.
  assign alu_a    = op_a_q;
  assign alu_b    = op_b_q;
  assign alu_sel  = op_sel_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NUM_REQ = 2) with a small
// behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_BAD  = 4'b0011;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [31:0]      alu_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [0:0]       rsp_id;
  logic [31:0]      rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [15:0]      stall_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_s     (alu_s),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU; undefined ops return a nonzero junk value.
  always_comb begin
    case (alu_sel)
      OP_AND:  alu_s = alu_a & alu_b;
      OP_OR:   alu_s = alu_a | alu_b;
      OP_ADD:  alu_s = alu_a + alu_b;
      OP_SUB:  alu_s = alu_a - alu_b;
      OP_SLT:  alu_s = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SLTU: alu_s = (alu_a < alu_b) ? 32'd1 : 32'd0;
      OP_NOR:  alu_s = ~(alu_a | alu_b);
      default: alu_s = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester with rsp_ready held high.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] ed,
                       input logic ez, input logic ee);
    logic [1:0] exp_rdy;
    req_valid      = 2'b00;
    req_valid[idx] = 1'b1;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_op[idx]    = op;
    rsp_ready      = 1'b1;
    exp_rdy        = 2'b01 << idx;
    #1;
    chk("op_grant_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    step();
    req_valid = 2'b00;
    chk("op_exec_ready", {30'd0, req_ready}, 32'd0);
    chk("op_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("op_exec_alu_a", alu_a, a);
    chk("op_exec_alu_sel", {28'd0, alu_sel}, {28'd0, op});
    step();
    chk("op_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_resp_id", {31'd0, rsp_id}, idx);
    chk("op_resp_data", rsp_data, ed);
    chk("op_resp_zero", {31'd0, rsp_zero}, {31'd0, ez});
    chk("op_resp_err", {31'd0, rsp_err}, {31'd0, ee});
    step();
    chk("op_back_idle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [0:0]  exp_id;
    logic [31:0] exp_data;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, {28'd0, OP_ADD});
    chk("rst_alu_a", alu_a, 32'd0);
    reset = 1'b0;
    step();

    // Basic add from requester 0: 5 + 3.
    do_op(0, 32'd5, 32'd3, OP_ADD, 32'd8, 1'b0, 1'b0);

    // Both requesting: last grant was 0, so 1,0,1,0.
    req_a[0] = 32'd10; req_b[0] = 32'd1; req_op[0] = OP_ADD;
    req_a[1] = 32'd20; req_b[1] = 32'd2; req_op[1] = OP_SUB;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = (k % 2 == 0) ? 1'b1 : 1'b0;
      exp_data = exp_id ? 32'd18 : 32'd11;
      #1;
      chk("rr_grant", {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
      step();
      chk("rr_exec_ready", {30'd0, req_ready}, 32'd0);
      step();
      chk("rr_resp_ready", {30'd0, req_ready}, 32'd0);
      chk("rr_resp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      chk("rr_resp_data", rsp_data, exp_data);
      step();
    end
    req_valid = 2'b00;

    // Zero result and unsigned compare.
    do_op(0, 32'd7, 32'd7, OP_SUB, 32'd0, 1'b1, 1'b0);
    do_op(0, 32'd1, 32'hFFFF_FFFF, OP_SLTU, 32'd1, 1'b0, 1'b0);
    do_op(1, 32'd1, 32'hFFFF_FFFF, OP_SLT, 32'd0, 1'b1, 1'b0);

    // Back-pressure: response held for 10 cycles, no grants meanwhile.
    req_valid = 2'b10;
    req_a[1] = 32'd2; req_b[1] = 32'd3; req_op[1] = OP_OR;
    rsp_ready = 1'b0;
    #1;
    chk("stall_grant", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b11;
    req_a[1] = 32'd100;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, 32'd3);
      chk("stall_id", {31'd0, rsp_id}, 32'd1);
      chk("stall_ready", {30'd0, req_ready}, 32'd0);
    end
`ifdef ALU_ARB_STALL_CNT_EN
    chk("stall_count10", {16'd0, stall_count}, 32'd10);
`endif
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    chk("stall_release", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_ARB_STALL_CNT_EN
    chk("stall_count_hold", {16'd0, stall_count}, 32'd10);
`endif

    // Undefined op is flagged, then a legal op clears the flag.
    do_op(0, 32'd3, 32'd4, OP_BAD, 32'd0, 1'b1, 1'b1);
    do_op(1, 32'd12, 32'd10, OP_AND, 32'd8, 1'b0, 1'b0);
    do_op(1, 32'h0F0F_0000, 32'h0000_00F0, OP_NOR, 32'hF0F0_FF0F, 1'b0, 1'b0);

    // Reset while in EXEC drops the operation.
    req_valid = 2'b01;
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = OP_ADD;
    #1;
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rexec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_data", rsp_data, 32'd0);
    chk("rexec_alu_sel", {28'd0, alu_sel}, {28'd0, OP_ADD});
    step();
    chk("rexec_idle_valid", {31'd0, rsp_valid}, 32'd0);
    req_a[1] = 32'd9; req_b[1] = 32'd4; req_op[1] = OP_SUB;
    req_valid = 2'b11;
    #1;
    chk("rexec_first_grant", {30'd0, req_ready}, 32'd1);
    step();
    step();
    chk("rexec_rsp_id0", {31'd0, rsp_id}, 32'd0);
    chk("rexec_rsp_data0", rsp_data, 32'd2);
    step();
    chk("rexec_second_grant", {30'd0, req_ready}, 32'd2);
    step();
    step();
    chk("rexec_rsp_id1", {31'd0, rsp_id}, 32'd1);
    chk("rexec_rsp_data1", rsp_data, 32'd5);
    req_valid = 2'b00;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
